// File: rtl/tvout_fb.sv
// Composite-video timing generator with an on-chip, CPU-writable framebuffer.
// Pixel rate comes from a clock-enable divider; the fetch/output pipeline is two pixel ticks deep.
module tvout_fb #(
    parameter int CLK_DIV  = 5,
    parameter int H_TOTAL  = 640,
    parameter int H_ACTIVE = 512,
    parameter int V_TOTAL  = 309,
    parameter int V_ACTIVE = 288,
    parameter int HS_START = 533,
    parameter int HS_END   = 580,
    parameter int VS_START = 290,
    parameter int VS_END   = 292,
    parameter int BPP      = 1,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              enable,
    input  logic              invert,
    output logic [BPP-1:0]    vout,
    output logic              sync_,
    output logic              vblank,
    output logic              frame_start
);

    localparam int PPW   = DATA_W / BPP;
    localparam int WPL   = H_ACTIVE / PPW;
    localparam int DEPTH = V_ACTIVE * H_ACTIVE / PPW;
    localparam int XW    = $clog2(H_TOTAL);
    localparam int YW    = $clog2(V_TOTAL);
    localparam int DIVW  = $clog2(CLK_DIV);

    logic [DIVW-1:0]   div_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] shreg_r;
    logic              active_1_r;
    logic              sync_1_r;
    logic              vblank_1_r;
    logic [BPP-1:0]    vout_r;
    logic              sync_n_r;
    logic              vblank_r;
    logic              frame_start_r;

    logic              pix_tick_s;
    logic              pre_tick_s;
    logic              x_last_s;
    logic              y_last_s;
    logic              active_s;
    logic              load_s;
    logic              in_sync_s;
    logic              vb_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] fetch_word_s;

    // Sync region map: hsync on normal lines, full-line vsync, half-line sync on VS_END.
    function automatic logic sync_at(input int xi, input int yi);
        logic s;
        if (yi < VS_START) begin
            s = (xi >= HS_START) && (xi < HS_END);
        end else if (yi < VS_END) begin
            s = 1'b1;
        end else if (yi == VS_END) begin
            s = (xi < H_TOTAL / 2);
        end else begin
            s = (xi >= HS_START) && (xi < HS_END);
        end
        return s;
    endfunction

    // Tick decode, active-area test, framebuffer address and word fetch.
    always_comb begin
        pix_tick_s   = (div_r == DIVW'(CLK_DIV - 1));
        pre_tick_s   = (div_r == DIVW'(CLK_DIV - 2));
        x_last_s     = (32'(x_r) == H_TOTAL - 1);
        y_last_s     = (32'(y_r) == V_TOTAL - 1);
        active_s     = (32'(x_r) < H_ACTIVE) && (32'(y_r) < V_ACTIVE);
        load_s       = ((32'(x_r) % PPW) == 0);
        in_sync_s    = sync_at(int'(x_r), int'(y_r));
        vb_s         = (32'(y_r) >= V_ACTIVE);
        rd_addr_s    = {ADDR_W{1'b0}};
        fetch_word_s = {DATA_W{1'b0}};
        if (active_s) begin
            rd_addr_s    = ADDR_W'(32'(y_r) * WPL + 32'(x_r) / PPW);
            fetch_word_s = mem[rd_addr_s];
        end else begin
            rd_addr_s    = {ADDR_W{1'b0}};
            fetch_word_s = {DATA_W{1'b0}};
        end
    end

    // Framebuffer write port; the same-edge fetch above sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Pixel clock-enable divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= {DIVW{1'b0}};
        end else if (pix_tick_s) begin
            div_r <= {DIVW{1'b0}};
        end else begin
            div_r <= div_r + DIVW'(1'b1);
        end
    end

    // Raster counters, wrapped by explicit compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= {XW{1'b0}};
            y_r <= {YW{1'b0}};
        end else if (pix_tick_s) begin
            if (x_last_s) begin
                x_r <= {XW{1'b0}};
                y_r <= y_last_s ? {YW{1'b0}} : y_r + YW'(1'b1);
            end else begin
                x_r <= x_r + XW'(1'b1);
            end
        end
    end

    // Frame pulse is set one clk early so it lands on the wrapping tick itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pre_tick_s && x_last_s && y_last_s;
        end
    end

    // Stage 1: word load / shift plus position attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r    <= {DATA_W{1'b0}};
            active_1_r <= 1'b0;
            sync_1_r   <= 1'b0;
            vblank_1_r <= 1'b0;
        end else if (pix_tick_s) begin
            shreg_r    <= load_s ? fetch_word_s : {shreg_r[DATA_W-BPP-1:0], {BPP{1'b0}}};
            active_1_r <= active_s;
            sync_1_r   <= in_sync_s;
            vblank_1_r <= vb_s;
        end
    end

    // Stage 2: registered video level, sync and vblank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vout_r   <= {BPP{1'b0}};
            sync_n_r <= 1'b1;
            vblank_r <= 1'b0;
        end else if (pix_tick_s) begin
            vout_r   <= active_1_r ? ((shreg_r[DATA_W-1 -: BPP] ^ {BPP{invert}}) & {BPP{enable}})
                                   : {BPP{1'b0}};
            sync_n_r <= ~sync_1_r;
            vblank_r <= vblank_1_r;
        end
    end

    assign vout        = vout_r;
    assign sync_       = sync_n_r;
    assign vblank      = vblank_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_tvout_fb.sv
// Bench for tvout_fb: two reduced-timing instances (1 and 2 bits per pixel) checked
// every clk against a raster-position model derived from tick counts.
module tb_tvout_fb;

    localparam int D   = 2;
    localparam int H   = 40;
    localparam int HA  = 32;
    localparam int V   = 20;
    localparam int VA  = 12;
    localparam int HSS = 34;
    localparam int HSE = 37;
    localparam int VSS = 14;
    localparam int VSE = 16;
    localparam int F   = H * V;
    localparam int DEP1 = 24;
    localparam int DEP2 = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        invert = 1'b0;
    logic        wr_en1 = 1'b0;
    logic [4:0]  wr_addr1 = 5'd0;
    logic [15:0] wr_data1 = 16'd0;
    logic        wr_en2 = 1'b0;
    logic [5:0]  wr_addr2 = 6'd0;
    logic [15:0] wr_data2 = 16'd0;
    logic [0:0]  vout1;
    logic [1:0]  vout2;
    logic        sync1, sync2, vb1, vb2, fs1, fs2;

    int checks = 0;
    int errors = 0;
    int c = 0;
    logic inv_s = 1'b0;
    logic en_s = 1'b1;
    logic [15:0] mem1 [0:DEP1-1];
    logic [15:0] f1   [0:DEP1-1];
    logic [15:0] mem2 [0:DEP2-1];
    logic [15:0] f2   [0:DEP2-1];
    int tclk = 0;
    int last_fs = -1;
    int low_cnt = 0;
    int fs_seen = 0;

    tvout_fb #(.CLK_DIV(D), .H_TOTAL(H), .H_ACTIVE(HA), .V_TOTAL(V), .V_ACTIVE(VA),
               .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE),
               .BPP(1), .DATA_W(16), .ADDR_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .enable(enable), .invert(invert), .vout(vout1), .sync_(sync1), .vblank(vb1),
        .frame_start(fs1));

    tvout_fb #(.CLK_DIV(D), .H_TOTAL(H), .H_ACTIVE(HA), .V_TOTAL(V), .V_ACTIVE(VA),
               .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE),
               .BPP(2), .DATA_W(16), .ADDR_W(6)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .enable(enable), .invert(invert), .vout(vout2), .sync_(sync2), .vblank(vb2),
        .frame_start(fs2));

    always #5 clk = ~clk;

    function automatic logic m_sync(input int x, input int y);
        if (y < VSS || y > VSE) return (x >= HSS && x < HSE);
        else if (y < VSE) return 1'b1;
        else return (x < H / 2);
    endfunction

    function automatic int m_pix(input logic [15:0] w, input int k, input int bpp);
        logic [15:0] s;
        s = w >> (16 - bpp * (k + 1));
        return int'(s) & ((1 << bpp) - 1);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: tick count since release, fetch snapshot (before this edge's write), memory.
    always @(posedge clk) begin
        int n, p, x, y;
        if (!rst_n) begin
            c = 0;
        end else begin
            if (c % D == D - 1) begin
                n = c / D; p = n % F; x = p % H; y = p / H;
                if (x < HA && y < VA && x % 16 == 0) f1[y * 2 + x / 16] = mem1[y * 2 + x / 16];
                if (x < HA && y < VA && x % 8 == 0)  f2[y * 4 + x / 8]  = mem2[y * 4 + x / 8];
                inv_s = invert;
                en_s  = enable;
            end
            c++;
        end
        if (wr_en1 && int'(wr_addr1) < DEP1) mem1[wr_addr1] = wr_data1;
        if (wr_en2 && int'(wr_addr2) < DEP2) mem2[wr_addr2] = wr_data2;
    end

    // Per-clk comparison of both instances against the model.
    always @(negedge clk) begin
        int n, q, x, y, e1, e2, es, evb, efs;
        e1 = 0; e2 = 0; es = 1; evb = 0; efs = 0;
        if (rst_n) begin
            n = c / D;
            efs = (c % D == D - 1 && n % F == F - 1) ? 1 : 0;
            if (n >= 2) begin
                q = (n - 2) % F; x = q % H; y = q / H;
                es  = m_sync(x, y) ? 0 : 1;
                evb = (y >= VA) ? 1 : 0;
                if (x < HA && y < VA) begin
                    e1 = (m_pix(f1[y * 2 + x / 16], x % 16, 1) ^ (inv_s ? 1 : 0)) & (en_s ? 1 : 0);
                    e2 = (m_pix(f2[y * 4 + x / 8], x % 8, 2) ^ (inv_s ? 3 : 0)) & (en_s ? 3 : 0);
                end
            end
        end
        check("vout1", vout1, e1);
        check("vout2", vout2, e2);
        check("sync1", sync1, es);
        check("sync2", sync2, es);
        check("vblank1", vb1, evb);
        check("vblank2", vb2, evb);
        check("frame_start1", fs1, efs);
        check("frame_start2", fs2, efs);
    end

    // Frame period and sync-low clk count per frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_fs = -1;
            low_cnt = 0;
        end else begin
            tclk++;
            if (!sync1) low_cnt++;
            if (fs1) begin
                if (last_fs >= 0) begin
                    check("frame_period", tclk - last_fs, 1600);
                    check("sync_low_clks", low_cnt, 302);
                end
                last_fs = tclk;
                low_cnt = 0;
                fs_seen++;
            end
        end
    end

    task automatic wait_disp(input int q);
        bit found;
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (rst_n && c % D == 0 && c / D >= 2 && (c / D - 2) % F == q) found = 1;
        end
        if (!found) check("wait_disp_timeout", 0, 1);
    endtask

    initial begin
        check("pin_sync_33_0", m_sync(33, 0), 0);
        check("pin_sync_34_0", m_sync(34, 0), 1);
        check("pin_sync_36_0", m_sync(36, 0), 1);
        check("pin_sync_37_0", m_sync(37, 0), 0);
        check("pin_sync_0_14", m_sync(0, 14), 1);
        check("pin_sync_39_15", m_sync(39, 15), 1);
        check("pin_sync_19_16", m_sync(19, 16), 1);
        check("pin_sync_20_16", m_sync(20, 16), 0);
        check("pin_sync_0_17", m_sync(0, 17), 0);
        check("pin_pix2_0", m_pix(16'hE400, 0, 2), 3);
        check("pin_pix2_1", m_pix(16'hE400, 1, 2), 2);
        check("pin_pix2_2", m_pix(16'hE400, 2, 2), 1);
        check("pin_pix2_3", m_pix(16'hE400, 3, 2), 0);
        check("pin_pix1_0", m_pix(16'h8001, 0, 1), 1);
        check("pin_pix1_1", m_pix(16'h8001, 1, 1), 0);
        check("pin_pix1_15", m_pix(16'h8001, 15, 1), 1);

        for (int i = 0; i < DEP2; i++) begin
            @(negedge clk);
            wr_en1   = (i < DEP1);
            wr_addr1 = 5'(i % 32);
            wr_data1 = (i == 0) ? 16'h8001 : (i == 16) ? 16'hFFFF : (i == 1) ? 16'h0000 : 16'($urandom);
            wr_en2   = 1'b1;
            wr_addr2 = 6'(i);
            wr_data2 = (i == 0) ? 16'hE400 : 16'($urandom);
        end
        @(negedge clk);
        wr_en1 = 1'b0; wr_en2 = 1'b0;
        check("reset_vout1", vout1, 0);
        check("reset_sync1", sync1, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        wait_disp(0);   check("l0_x0_v1", vout1, 1); check("l0_x0_v2", vout2, 3);
        wait_disp(1);   check("l0_x1_v1", vout1, 0); check("l0_x1_v2", vout2, 2);
        wait_disp(2);   check("l0_x2_v2", vout2, 1);
        wait_disp(15);  check("l0_x15_v1", vout1, 1);
        wait_disp(8 * H + 5); check("l8_x5_v1", vout1, 1);
        wait_disp(14 * H);    check("l14_sync", sync1, 0); check("l14_vblank", vb1, 1);
        repeat (2 * 1600) @(negedge clk);

        invert = 1'b1;
        wait_disp(1);  check("inv_l0_x1", vout1, 1);
        wait_disp(15); check("inv_l0_x15", vout1, 0);
        repeat (1600) @(negedge clk);
        invert = 1'b0;
        enable = 1'b0;
        repeat (1600) @(negedge clk);
        enable = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (c % D == D - 1 && (c / D) % F == 0) break;
        end
        wr_en2 = 1'b1; wr_addr2 = 6'd0; wr_data2 = 16'h1234;
        @(negedge clk);
        wr_en2 = 1'b0;
        wait_disp(0); check("rbw_old_word", vout2, 3);
        wait_disp(0); check("rbw_new_word", vout2, 0);

        repeat (3000) begin
            @(negedge clk);
            wr_en1   = ($urandom % 3 == 0);
            wr_addr1 = 5'($urandom % 32);
            wr_data1 = 16'($urandom);
            wr_en2   = ($urandom % 3 == 0);
            wr_addr2 = 6'($urandom % 64);
            wr_data2 = 16'($urandom);
            if ($urandom % 200 == 0) invert = ~invert;
            if ($urandom % 200 == 0) enable = ~enable;
        end
        @(negedge clk);
        wr_en1 = 1'b0; wr_en2 = 1'b0; invert = 1'b0; enable = 1'b1;

        wait_disp(VSS * H + 10);
        check("pre_reset_sync", sync1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_vout1", vout1, 0);
        check("async_vout2", vout2, 0);
        check("async_sync1", sync1, 1);
        check("async_sync2", sync2, 1);
        check("async_vblank", vb1, 0);
        check("async_fs", fs1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1800) @(negedge clk);
        check("frames_seen", (fs_seen >= 3) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
